// File: rtl/coherence_bus_ctrl_pkg.sv
// Shared types for the two-core coherence bus: RAM handshake state, FSM encodings, request kinds.
package cpu_types_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

package coherence_bus_ctrl_pkg;
    localparam int NCORES            = 2;
    localparam int WORD_W            = 32;
    localparam int SNOOP_LAT_DEFAULT = 1;

    typedef logic core_id_t;

    typedef logic [2:0] bus_state_t;
    localparam bus_state_t IDLE   = 3'd0;
    localparam bus_state_t RAMW   = 3'd1;
    localparam bus_state_t RAMR_I = 3'd2;
    localparam bus_state_t SNP    = 3'd3;
    localparam bus_state_t C2C0   = 3'd4;
    localparam bus_state_t C2C1   = 3'd5;
    localparam bus_state_t LD0    = 3'd6;
    localparam bus_state_t LD1    = 3'd7;

    typedef enum logic [2:0] {
        REQ_WB,
        REQ_RD,
        REQ_RDX,
        REQ_INV,
        REQ_IF
    } req_kind_t;

    // dcache traffic always outranks the icache of the same core
    function automatic req_kind_t decode_kind(input logic wen, input logic ren, input logic trans);
        if (wen)
            return REQ_WB;
        else if (ren && trans)
            return REQ_RDX;
        else if (ren)
            return REQ_RD;
        else if (trans)
            return REQ_INV;
        else
            return REQ_IF;
    endfunction
endpackage

// File: rtl/coherence_bus_ctrl_if.sv
// Cache/RAM side signal bundle of the coherence bus; slave = controller view, master = caches + RAM.
interface coherence_bus_ctrl_if;
    import coherence_bus_ctrl_pkg::*;
    import cpu_types_pkg::*;

    logic [NCORES-1:0]             iREN;
    logic [NCORES-1:0][WORD_W-1:0] iaddr;
    logic [NCORES-1:0]             iwait;
    logic [WORD_W-1:0]             iload;
    logic [NCORES-1:0]             dREN;
    logic [NCORES-1:0]             dWEN;
    logic [NCORES-1:0][WORD_W-1:0] daddr;
    logic [NCORES-1:0][WORD_W-1:0] dstore;
    logic [NCORES-1:0]             cctrans;
    logic [NCORES-1:0]             ccwrite;
    logic [NCORES-1:0]             dwait;
    logic [WORD_W-1:0]             dload;
    logic [NCORES-1:0]             ccwait;
    logic [NCORES-1:0]             ccinv;
    logic [NCORES-1:0][WORD_W-1:0] ccsnoopaddr;
    logic                          ramREN;
    logic                          ramWEN;
    logic [WORD_W-1:0]             ramaddr;
    logic [WORD_W-1:0]             ramstore;
    logic [WORD_W-1:0]             ramload;
    ramstate_t                     ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
        output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
        input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/coherence_bus_ctrl_rr_arbiter.sv
// Two-core round-robin grant with per-core request decode; combinational grant, registered rr_ptr.
// Grant is only consumed when en is high; rr_ptr records the last core granted.
module bus_rr_arbiter
    import coherence_bus_ctrl_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              en,
    input  logic [NCORES-1:0] iREN,
    input  logic [NCORES-1:0] dREN,
    input  logic [NCORES-1:0] dWEN,
    input  logic [NCORES-1:0] cctrans,
    output logic              gnt_vld,
    output core_id_t          gnt_core,
    output req_kind_t         gnt_kind
);
    core_id_t          rr_ptr;
    logic [NCORES-1:0] req;
    req_kind_t         kind [NCORES];

    always_comb begin
        for (int c = 0; c < NCORES; c++) begin
            req[c]  = dREN[c] | dWEN[c] | cctrans[c] | iREN[c];
            kind[c] = decode_kind(dWEN[c], dREN[c], cctrans[c]);
        end
        gnt_vld = |req;
        // on a tie the core that was not served last goes first
        if (req[0] && req[1])
            gnt_core = !rr_ptr;
        else
            gnt_core = req[1];
        gnt_kind = kind[gnt_core];
    end

    always_ff @(posedge CLK) begin
        if (RST)
            rr_ptr <= 1'b0;
        else if (en && gnt_vld)
            rr_ptr <= gnt_core;
    end
endmodule

// File: rtl/coherence_bus_ctrl.sv
// Two-core MSI bus controller: arbitrates one RAM port, snoops the other dcache, cache-to-cache dirty transfer.
// Clean RD miss = grant + SNOOP_LAT + 2 cycles; RAM BUSY/ERROR stalls with no handshake; dropped requests abort.
module coherence_bus_ctrl
    import coherence_bus_ctrl_pkg::*;
    import cpu_types_pkg::*;
#(
    parameter int SNOOP_LAT = SNOOP_LAT_DEFAULT
) (
    input logic                CLK,
    input logic                RST,
    coherence_bus_ctrl_if.slave bus
);
    bus_state_t state, state_n;
    core_id_t   r, r_n, o;
    req_kind_t  kind, kind_n;
    logic [7:0] snp_cnt, snp_cnt_n;
    logic       req_act;
    logic       access;
    logic       gnt_vld;
    core_id_t   gnt_core;
    req_kind_t  gnt_kind;

    bus_rr_arbiter u_arb (
        .CLK      (CLK),
        .RST      (RST),
        .en       (state == IDLE),
        .iREN     (bus.iREN),
        .dREN     (bus.dREN),
        .dWEN     (bus.dWEN),
        .cctrans  (bus.cctrans),
        .gnt_vld  (gnt_vld),
        .gnt_core (gnt_core),
        .gnt_kind (gnt_kind)
    );

    assign o      = !r;
    assign access = (bus.ramstate == ACCESS);

    always_comb begin
        req_act = 1'b0;
        case (kind)
            REQ_WB:          req_act = bus.dWEN[r];
            REQ_RD, REQ_RDX: req_act = bus.dREN[r];
            REQ_INV:         req_act = bus.cctrans[r];
            default:         req_act = bus.iREN[r];
        endcase
    end

    always_comb begin
        state_n          = state;
        r_n              = r;
        kind_n           = kind;
        snp_cnt_n        = snp_cnt;
        bus.dwait        = '1;
        bus.iwait        = '1;
        bus.ccwait       = '0;
        bus.ccinv        = '0;
        bus.ccsnoopaddr  = '0;
        bus.ramREN       = 1'b0;
        bus.ramWEN       = 1'b0;
        bus.ramaddr      = '0;
        bus.ramstore     = '0;
        bus.dload        = '0;
        bus.iload        = '0;

        case (state)
            IDLE: begin
                if (gnt_vld) begin
                    r_n       = gnt_core;
                    kind_n    = gnt_kind;
                    snp_cnt_n = '0;
                    case (gnt_kind)
                        REQ_WB:  state_n = RAMW;
                        REQ_IF:  state_n = RAMR_I;
                        default: state_n = SNP;
                    endcase
                end
            end
            RAMW: begin
                // a block writeback holds dWEN across both words; dropping it ends the burst
                if (!req_act) begin
                    state_n = IDLE;
                end else begin
                    bus.ramWEN   = 1'b1;
                    bus.ramaddr  = bus.daddr[r];
                    bus.ramstore = bus.dstore[r];
                    if (access)
                        bus.dwait[r] = 1'b0;
                end
            end
            RAMR_I: begin
                if (!req_act) begin
                    state_n = IDLE;
                end else begin
                    bus.ramREN  = 1'b1;
                    bus.ramaddr = bus.iaddr[r];
                    if (access) begin
                        bus.iload    = bus.ramload;
                        bus.iwait[r] = 1'b0;
                        state_n      = IDLE;
                    end
                end
            end
            SNP: begin
                if (!req_act) begin
                    state_n = IDLE;
                end else begin
                    bus.ccwait[o]      = 1'b1;
                    bus.ccinv[o]       = (kind != REQ_RD);
                    bus.ccsnoopaddr[o] = bus.daddr[r];
                    snp_cnt_n          = snp_cnt + 8'd1;
                    if (kind == REQ_INV) begin
                        if (snp_cnt == 8'(SNOOP_LAT)) begin
                            bus.dwait[r] = 1'b0;
                            state_n      = IDLE;
                        end
                    end else if (snp_cnt == 8'(SNOOP_LAT - 1)) begin
                        state_n = bus.ccwrite[o] ? C2C0 : LD0;
                    end
                end
            end
            C2C0, C2C1: begin
                // once the first word has moved, the supplier still needs its second handshake
                if (state == C2C0 && !req_act) begin
                    state_n = IDLE;
                end else begin
                    bus.ccwait[o]      = 1'b1;
                    bus.ccinv[o]       = (kind == REQ_RDX);
                    bus.ccsnoopaddr[o] = bus.daddr[r];
                    bus.dload          = bus.dstore[o];
                    bus.ramWEN         = 1'b1;
                    bus.ramaddr        = bus.daddr[r];
                    bus.ramstore       = bus.dstore[o];
                    if (access) begin
                        bus.dwait[o] = 1'b0;
                        if (req_act)
                            bus.dwait[r] = 1'b0;
                        state_n = (state == C2C0) ? C2C1 : IDLE;
                    end
                end
            end
            LD0, LD1: begin
                if (!req_act) begin
                    state_n = IDLE;
                end else begin
                    bus.ramREN  = 1'b1;
                    bus.ramaddr = bus.daddr[r];
                    if (access) begin
                        bus.dload    = bus.ramload;
                        bus.dwait[r] = 1'b0;
                        state_n      = (state == LD0) ? LD1 : IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            r       <= 1'b0;
            kind    <= REQ_RD;
            snp_cnt <= '0;
        end else begin
            state   <= state_n;
            r       <= r_n;
            kind    <= kind_n;
            snp_cnt <= snp_cnt_n;
        end
    end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl: inputs change on the falling edge, outputs sampled 1ns later.
module tb_coherence_bus_ctrl;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    coherence_bus_ctrl_if bus();

    coherence_bus_ctrl #(.SNOOP_LAT(1)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // {dwait[1:0], iwait[1:0], ccwait[1:0], ccinv[1:0], ramREN, ramWEN}
    logic [9:0] ctl;
    assign ctl = {bus.dwait, bus.iwait, bus.ccwait, bus.ccinv, bus.ramREN, bus.ramWEN};
    localparam logic [9:0] CTL_IDLE = 10'b11_11_00_00_0_0;

    task automatic nxt();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        bus.iREN     = '0;
        bus.iaddr    = '0;
        bus.dREN     = '0;
        bus.dWEN     = '0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.cctrans  = '0;
        bus.ccwrite  = '0;
        bus.ramload  = '0;
        bus.ramstate = FREE;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.dREN     = 2'b11;
        bus.ramstate = ACCESS;
        nxt(); #1;
        n_checks++; if (ctl !== CTL_IDLE) begin n_fail++; $display("FAIL reset_hold ctl: got %b expected %b", ctl, CTL_IDLE); end
        nxt(); #1;
        n_checks++; if ({bus.ramaddr, bus.ramstore, bus.dload, bus.iload} !== 128'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {bus.ramaddr, bus.ramstore, bus.dload, bus.iload}); end
        nxt(); RST = 1'b0; idle_inputs(); #1;
        n_checks++; if (ctl !== CTL_IDLE) begin n_fail++; $display("FAIL reset_release ctl: got %b expected %b", ctl, CTL_IDLE); end
    endtask

    task automatic test_inv();
        nxt(); bus.cctrans = 2'b10; bus.daddr[1] = 32'h40; #1;
        n_checks++; if (ctl !== CTL_IDLE) begin n_fail++; $display("FAIL inv_grant ctl: got %b expected %b", ctl, CTL_IDLE); end
        nxt(); #1;
        n_checks++; if (ctl !== 10'b11_11_01_01_0_0) begin n_fail++; $display("FAIL inv_snp1 ctl: got %b expected %b", ctl, 10'b11_11_01_01_0_0); end
        n_checks++; if (bus.ccsnoopaddr[0] !== 32'h40) begin n_fail++; $display("FAIL inv_snp1 addr: got %h expected 40", bus.ccsnoopaddr[0]); end
        nxt(); #1;
        n_checks++; if (ctl !== 10'b01_11_01_01_0_0) begin n_fail++; $display("FAIL inv_snp2 ctl: got %b expected %b", ctl, 10'b01_11_01_01_0_0); end
        n_checks++; if (bus.ccsnoopaddr[0] !== 32'h40) begin n_fail++; $display("FAIL inv_snp2 addr: got %h expected 40", bus.ccsnoopaddr[0]); end
        nxt(); bus.cctrans = 2'b00; #1;
        n_checks++; if (ctl !== CTL_IDLE) begin n_fail++; $display("FAIL inv_done ctl: got %b expected %b", ctl, CTL_IDLE); end
    endtask

    task automatic test_rd_clean();
        nxt(); bus.dREN = 2'b01; bus.daddr[0] = 32'h100; #1;
        n_checks++; if (ctl !== CTL_IDLE) begin n_fail++; $display("FAIL rd_grant ctl: got %b expected %b", ctl, CTL_IDLE); end
        nxt(); bus.ccwrite = 2'b00; #1;
        n_checks++; if (ctl !== 10'b11_11_10_00_0_0) begin n_fail++; $display("FAIL rd_snp ctl: got %b expected %b", ctl, 10'b11_11_10_00_0_0); end
        n_checks++; if (bus.ccsnoopaddr[1] !== 32'h100) begin n_fail++; $display("FAIL rd_snp addr: got %h expected 100", bus.ccsnoopaddr[1]); end
        nxt(); bus.ramstate = ACCESS; bus.ramload = 32'hA; #1;
        n_checks++; if (ctl !== 10'b10_11_00_00_1_0) begin n_fail++; $display("FAIL rd_ld0 ctl: got %b expected %b", ctl, 10'b10_11_00_00_1_0); end
        n_checks++; if ({bus.ramaddr, bus.dload} !== {32'h100, 32'hA}) begin n_fail++; $display("FAIL rd_ld0 addr/data: got %h expected %h", {bus.ramaddr, bus.dload}, {32'h100, 32'hA}); end
        nxt(); bus.daddr[0] = 32'h104; bus.ramload = 32'hB; #1;
        n_checks++; if (ctl !== 10'b10_11_00_00_1_0) begin n_fail++; $display("FAIL rd_ld1 ctl: got %b expected %b", ctl, 10'b10_11_00_00_1_0); end
        n_checks++; if ({bus.ramaddr, bus.dload} !== {32'h104, 32'hB}) begin n_fail++; $display("FAIL rd_ld1 addr/data: got %h expected %h", {bus.ramaddr, bus.dload}, {32'h104, 32'hB}); end
        nxt(); bus.dREN = 2'b00; bus.ramstate = FREE; #1;
        n_checks++; if (ctl !== CTL_IDLE) begin n_fail++; $display("FAIL rd_done ctl: got %b expected %b", ctl, CTL_IDLE); end
    endtask

    task automatic test_c2c();
        nxt(); bus.dREN = 2'b01; bus.cctrans = 2'b01; bus.daddr[0] = 32'h200; #1;
        n_checks++; if (ctl !== CTL_IDLE) begin n_fail++; $display("FAIL c2c_grant ctl: got %b expected %b", ctl, CTL_IDLE); end
        nxt(); bus.ccwrite = 2'b10; #1;
        n_checks++; if (ctl !== 10'b11_11_10_10_0_0) begin n_fail++; $display("FAIL c2c_snp ctl: got %b expected %b", ctl, 10'b11_11_10_10_0_0); end
        n_checks++; if (bus.ccsnoopaddr[1] !== 32'h200) begin n_fail++; $display("FAIL c2c_snp addr: got %h expected 200", bus.ccsnoopaddr[1]); end
        nxt(); bus.dstore[1] = 32'h11; bus.ramstate = BUSY; #1;
        n_checks++; if ({bus.dwait, bus.ccwait, bus.ramREN, bus.ramWEN} !== 6'b11_10_0_1) begin n_fail++; $display("FAIL c2c_busy ctl: got %b expected %b", {bus.dwait, bus.ccwait, bus.ramREN, bus.ramWEN}, 6'b11_10_0_1); end
        nxt(); bus.ramstate = ACCESS; #1;
        n_checks++; if ({bus.dwait, bus.ccwait, bus.ramREN, bus.ramWEN} !== 6'b00_10_0_1) begin n_fail++; $display("FAIL c2c_w0 ctl: got %b expected %b", {bus.dwait, bus.ccwait, bus.ramREN, bus.ramWEN}, 6'b00_10_0_1); end
        n_checks++; if ({bus.ramaddr, bus.ramstore, bus.dload} !== {32'h200, 32'h11, 32'h11}) begin n_fail++; $display("FAIL c2c_w0 data: got %h expected %h", {bus.ramaddr, bus.ramstore, bus.dload}, {32'h200, 32'h11, 32'h11}); end
        nxt(); bus.daddr[0] = 32'h204; bus.dstore[1] = 32'h22; #1;
        n_checks++; if ({bus.dwait, bus.ccwait, bus.ramREN, bus.ramWEN} !== 6'b00_10_0_1) begin n_fail++; $display("FAIL c2c_w1 ctl: got %b expected %b", {bus.dwait, bus.ccwait, bus.ramREN, bus.ramWEN}, 6'b00_10_0_1); end
        n_checks++; if ({bus.ramaddr, bus.ramstore, bus.dload} !== {32'h204, 32'h22, 32'h22}) begin n_fail++; $display("FAIL c2c_w1 data: got %h expected %h", {bus.ramaddr, bus.ramstore, bus.dload}, {32'h204, 32'h22, 32'h22}); end
        nxt(); idle_inputs(); #1;
        n_checks++; if (ctl !== CTL_IDLE) begin n_fail++; $display("FAIL c2c_done ctl: got %b expected %b", ctl, CTL_IDLE); end
    endtask

    task automatic test_back_to_back();
        nxt(); bus.dREN = 2'b11; bus.daddr[0] = 32'h300; bus.daddr[1] = 32'h380; #1;
        n_checks++; if (ctl !== CTL_IDLE) begin n_fail++; $display("FAIL rr_tie1 ctl: got %b expected %b", ctl, CTL_IDLE); end
        nxt(); #1;
        n_checks++; if ({ctl, bus.ccsnoopaddr[0]} !== {10'b11_11_01_00_0_0, 32'h380}) begin n_fail++; $display("FAIL rr_first_core1: got %h expected %h", {ctl, bus.ccsnoopaddr[0]}, {10'b11_11_01_00_0_0, 32'h380}); end
        nxt(); bus.ramstate = ACCESS; bus.ramload = 32'h5; #1;
        n_checks++; if ({ctl, bus.ramaddr} !== {10'b01_11_00_00_1_0, 32'h380}) begin n_fail++; $display("FAIL rr_c1_ld0: got %h expected %h", {ctl, bus.ramaddr}, {10'b01_11_00_00_1_0, 32'h380}); end
        nxt(); bus.daddr[1] = 32'h384; bus.ramload = 32'h6; #1;
        n_checks++; if ({ctl, bus.ramaddr} !== {10'b01_11_00_00_1_0, 32'h384}) begin n_fail++; $display("FAIL rr_c1_ld1: got %h expected %h", {ctl, bus.ramaddr}, {10'b01_11_00_00_1_0, 32'h384}); end
        nxt(); bus.ramstate = FREE; bus.daddr[1] = 32'h390; #1;
        n_checks++; if (ctl !== CTL_IDLE) begin n_fail++; $display("FAIL rr_tie2 ctl: got %b expected %b", ctl, CTL_IDLE); end
        nxt(); bus.dREN = 2'b01; #1;
        n_checks++; if ({ctl, bus.ccsnoopaddr[1]} !== {10'b11_11_10_00_0_0, 32'h300}) begin n_fail++; $display("FAIL rr_second_core0: got %h expected %h", {ctl, bus.ccsnoopaddr[1]}, {10'b11_11_10_00_0_0, 32'h300}); end
        nxt(); bus.ramstate = ACCESS; bus.ramload = 32'h7; #1;
        n_checks++; if ({ctl, bus.ramaddr, bus.dload} !== {10'b10_11_00_00_1_0, 32'h300, 32'h7}) begin n_fail++; $display("FAIL rr_c0_ld0: got %h expected %h", {ctl, bus.ramaddr, bus.dload}, {10'b10_11_00_00_1_0, 32'h300, 32'h7}); end
        nxt(); bus.daddr[0] = 32'h304; #1;
        n_checks++; if ({ctl, bus.ramaddr} !== {10'b10_11_00_00_1_0, 32'h304}) begin n_fail++; $display("FAIL rr_c0_ld1: got %h expected %h", {ctl, bus.ramaddr}, {10'b10_11_00_00_1_0, 32'h304}); end
        nxt(); idle_inputs(); #1;
        n_checks++; if (ctl !== CTL_IDLE) begin n_fail++; $display("FAIL rr_done ctl: got %b expected %b", ctl, CTL_IDLE); end
    endtask

    task automatic test_wb_then_if();
        nxt(); bus.iREN = 2'b01; bus.iaddr[0] = 32'h500; bus.dWEN = 2'b01; bus.daddr[0] = 32'h600; bus.dstore[0] = 32'h77; #1;
        n_checks++; if (ctl !== CTL_IDLE) begin n_fail++; $display("FAIL wb_grant ctl: got %b expected %b", ctl, CTL_IDLE); end
        nxt(); bus.ramstate = ERROR; #1;
        n_checks++; if ({ctl, bus.ramaddr, bus.ramstore} !== {10'b11_11_00_00_0_1, 32'h600, 32'h77}) begin n_fail++; $display("FAIL wb_err0: got %h expected %h", {ctl, bus.ramaddr, bus.ramstore}, {10'b11_11_00_00_0_1, 32'h600, 32'h77}); end
        nxt(); bus.ramstate = BUSY; #1;
        n_checks++; if (ctl !== 10'b11_11_00_00_0_1) begin n_fail++; $display("FAIL wb_busy0 ctl: got %b expected %b", ctl, 10'b11_11_00_00_0_1); end
        nxt(); bus.ramstate = ACCESS; #1;
        n_checks++; if (ctl !== 10'b10_11_00_00_0_1) begin n_fail++; $display("FAIL wb_acc0 ctl: got %b expected %b", ctl, 10'b10_11_00_00_0_1); end
        nxt(); bus.daddr[0] = 32'h604; bus.dstore[0] = 32'h88; bus.ramstate = ERROR; #1;
        n_checks++; if ({ctl, bus.ramaddr, bus.ramstore} !== {10'b11_11_00_00_0_1, 32'h604, 32'h88}) begin n_fail++; $display("FAIL wb_err1: got %h expected %h", {ctl, bus.ramaddr, bus.ramstore}, {10'b11_11_00_00_0_1, 32'h604, 32'h88}); end
        nxt(); bus.ramstate = ACCESS; #1;
        n_checks++; if (ctl !== 10'b10_11_00_00_0_1) begin n_fail++; $display("FAIL wb_acc1 ctl: got %b expected %b", ctl, 10'b10_11_00_00_0_1); end
        nxt(); bus.dWEN = 2'b00; bus.ramstate = FREE; #1;
        n_checks++; if (ctl !== CTL_IDLE) begin n_fail++; $display("FAIL wb_release ctl: got %b expected %b", ctl, CTL_IDLE); end
        nxt(); #1;
        n_checks++; if (ctl !== CTL_IDLE) begin n_fail++; $display("FAIL if_grant ctl: got %b expected %b", ctl, CTL_IDLE); end
        nxt(); bus.ramstate = ACCESS; bus.ramload = 32'hCAFE; #1;
        n_checks++; if ({ctl, bus.ramaddr, bus.iload} !== {10'b11_10_00_00_1_0, 32'h500, 32'hCAFE}) begin n_fail++; $display("FAIL if_fetch: got %h expected %h", {ctl, bus.ramaddr, bus.iload}, {10'b11_10_00_00_1_0, 32'h500, 32'hCAFE}); end
        nxt(); idle_inputs(); #1;
        n_checks++; if (ctl !== CTL_IDLE) begin n_fail++; $display("FAIL if_done ctl: got %b expected %b", ctl, CTL_IDLE); end
    endtask

    task automatic test_drop();
        nxt(); bus.dREN = 2'b01; bus.daddr[0] = 32'h800; #1;
        nxt(); #1;
        n_checks++; if (ctl !== 10'b11_11_10_00_0_0) begin n_fail++; $display("FAIL drop_snp ctl: got %b expected %b", ctl, 10'b11_11_10_00_0_0); end
        nxt(); bus.ramstate = BUSY; #1;
        n_checks++; if (ctl !== 10'b11_11_00_00_1_0) begin n_fail++; $display("FAIL drop_ld0 ctl: got %b expected %b", ctl, 10'b11_11_00_00_1_0); end
        nxt(); bus.dREN = 2'b00; bus.ramstate = ACCESS; #1;
        n_checks++; if (ctl !== CTL_IDLE) begin n_fail++; $display("FAIL drop_nopulse ctl: got %b expected %b", ctl, CTL_IDLE); end
        nxt(); #1;
        n_checks++; if (ctl !== CTL_IDLE) begin n_fail++; $display("FAIL drop_idle ctl: got %b expected %b", ctl, CTL_IDLE); end
        nxt(); idle_inputs();
    endtask

    task automatic test_reset_mid();
        nxt(); bus.dREN = 2'b10; bus.daddr[1] = 32'h700; #1;
        nxt(); #1;
        n_checks++; if (ctl !== 10'b11_11_01_00_0_0) begin n_fail++; $display("FAIL rstmid_snp ctl: got %b expected %b", ctl, 10'b11_11_01_00_0_0); end
        nxt(); bus.ramstate = ACCESS; bus.ramload = 32'h1; #1;
        n_checks++; if (ctl !== 10'b01_11_00_00_1_0) begin n_fail++; $display("FAIL rstmid_ld0 ctl: got %b expected %b", ctl, 10'b01_11_00_00_1_0); end
        nxt(); bus.daddr[1] = 32'h704; bus.ramstate = BUSY; RST = 1'b1; #1;
        n_checks++; if ({ctl, bus.ramaddr} !== {10'b11_11_00_00_1_0, 32'h704}) begin n_fail++; $display("FAIL rstmid_ld1: got %h expected %h", {ctl, bus.ramaddr}, {10'b11_11_00_00_1_0, 32'h704}); end
        nxt(); RST = 1'b0; bus.ramstate = ACCESS; #1;
        n_checks++; if ({ctl, bus.ramaddr} !== {CTL_IDLE, 32'h0}) begin n_fail++; $display("FAIL rstmid_idle: got %h expected %h", {ctl, bus.ramaddr}, {CTL_IDLE, 32'h0}); end
        nxt(); idle_inputs();
        nxt();
    endtask

    initial begin
        test_reset();
        test_inv();
        test_rd_clean();
        test_c2c();
        test_back_to_back();
        test_wb_then_if();
        test_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1);
    end
endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
- Bus/coherence controller directly downstream of the two per-core dcaches (and icaches).
- Consumes their miss, writeback and cctrans/ccwrite traffic, and arbitrates a single RAM port.
- Drives snoops (ccwait/ccinv/ccsnoopaddr) into the non-requesting dcache and returns dwait/dload/iwait/iload.
- Implements MSI-style invalidate-on-write with cache-to-cache transfer of dirty blocks (2-word blocks).

Parameters:
- NCORES, 2, number of cores; only 2 supported. The "other" core of c is o = !c.
- WORD_W, 32, data/address width.
- SNOOP_LAT, 1, cycles ccwait is held before ccwrite[o] is sampled.

Ports:
- CLK  in  1  clock
- RST  in  1  reset; one clock CLK, reset RST is synchronous and active-high
- iREN  in  NCORES  icache fetch request per core
- iaddr  in  NCORES*32  icache fetch address
- iwait  out  NCORES  low for one cycle = iload valid
- iload  out  32  fetched word (shared; valid for granted core)
- dREN  in  NCORES  dcache read request
- dWEN  in  NCORES  dcache write(back) request
- daddr  in  NCORES*32  dcache address
- dstore  in  NCORES*32  dcache write data / snoop-supplied data
- cctrans  in  NCORES  coherence transaction (read-exclusive or invalidate)
- ccwrite  in  NCORES  snooped block present and dirty
- dwait  out  NCORES  low for one cycle = transfer complete
- dload  out  32  read data to requester
- ccwait  out  NCORES  snoop in progress on that core
- ccinv  out  NCORES  invalidate snooped block
- ccsnoopaddr  out  NCORES*32  snoop address
- ramREN  out  1  RAM read
- ramWEN  out  1  RAM write
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE/BUSY/ACCESS/ERROR; ACCESS = access done this cycle

Behaviour:
- Reset / defaults:
  - RST sampled at posedge: state=IDLE, rr_ptr=0.
  - Combinational defaults every cycle: dwait=iwait='1, ccwait=ccinv='0, ramREN=ramWEN=0, addresses/data=0.
  - RST mid-transaction: abort, IDLE next cycle, no dwait/iwait pulse.
- Arbitration in IDLE:
  - Request per core = dREN|dWEN|cctrans|iREN. Within a core, dcache beats icache.
  - Between cores, round-robin: the core != last granted wins a tie, and rr_ptr updates on grant.
  - Grant latches r (core) and kind; the transaction starts next cycle.
- Request decode, dcache kinds (priority dWEN > dREN > cctrans-only):
  - WB: dWEN.
  - RD: dREN & !cctrans.
  - RDX: dREN & cctrans.
  - INV: cctrans & !dREN & !dWEN.
- WB:
  - RAMW: ramWEN=1, ramaddr=daddr[r], ramstore=dstore[r].
  - On ACCESS: dwait[r]=0 that cycle; stay in RAMW while dWEN[r] is held (second word), else IDLE.
- IF: RAMR_I: ramREN=1, ramaddr=iaddr[r]; on ACCESS iload=ramload, iwait[r]=0, go to IDLE.
- INV:
  - SNP: ccwait[o]=1, ccinv[o]=1, ccsnoopaddr[o]=daddr[r] for SNOOP_LAT+1 cycles.
  - Then dwait[r]=0 for one cycle and return to IDLE.
- RD/RDX snoop phase:
  - SNP: ccwait[o]=1, ccsnoopaddr[o]=daddr[r], ccinv[o]=(kind==RDX), held SNOOP_LAT cycles.
  - Then sample ccwrite[o]: 1 -> C2C0, 0 -> LD0.
- C2C0/C2C1 (dirty transfer), ccwait[o] held throughout:
  - dload=dstore[o]; ramWEN=1, ramaddr=daddr[r], ramstore=dstore[o] (memory updated in parallel).
  - On ACCESS: dwait[r]=0, dwait[o]=0, advance C2C0->C2C1->IDLE.
  - If dREN[r] has dropped after C2C0: skip to C2C1 (o still needs its second handshake), then IDLE.
- LD0/LD1:
  - ramREN=1, ramaddr=daddr[r], ccwait[o]=0.
  - On ACCESS: dload=ramload, dwait[r]=0, advance LD0->LD1->IDLE.
  - IDLE early if dREN[r] drops after LD0.
- Boundaries:
  - ramstate ERROR is treated as BUSY (retry, no handshake).
  - Requester drops its request before ACCESS: return to IDLE next cycle with no pulse. C2C1 is exempt.
  - A core is never snooped while it is the granted requester. ccwait and dwait are never simultaneously active to the same core except in C2C.
  - Latency, FREE RAM with ACCESS on the first cycle:
    - RD clean miss: 1 grant + SNOOP_LAT + 2 cycles.
    - INV: 1 + SNOOP_LAT + 1 cycles.

Decomposition:
- Shared package (bus_types_pkg): bus_state_t enum (IDLE, RAMW, RAMR_I, SNP, C2C0, C2C1, LD0, LD1), req_kind_t enum (WB, RD, RDX, INV, IF), core_id_t.
- ramstate_t comes from cpu_types_pkg.
- One sub-module, bus_rr_arbiter: combinational request/priority logic plus the rr_ptr register; outputs grant valid, core and kind.

Test Plan:
- Core0 dREN daddr=0x100, core1 block absent (ccwrite[1]=0), RAM returns 0xA,0xB -> ccwait[1] pulses with ccinv[1]=0; core0 gets dwait low twice with dload=0xA then 0xB.
- Core0 dREN+cctrans 0x200, core1 dirty (ccwrite=1, dstore 0x11,0x22) -> ccinv[1]=1; ramWEN writes 0x11,0x22 to 0x200; dload=0x11,0x22; dwait low to both cores each word.
- Core1 cctrans only, addr 0x40 -> ccwait[0]=ccinv[0]=1 with ccsnoopaddr[0]=0x40 for 2 cycles; then dwait[1]=0 one cycle; no RAM access.
- Both cores dREN in the same cycle, rr_ptr=0 -> core1 granted first, core0 served after; next tie goes to core0.
- Core0 iREN and dWEN together -> dWEN serviced first; iwait[0] low only after the write completes; ramstate ERROR cycles inserted -> no handshake until ACCESS.
- RST asserted during LD1 -> next cycle state IDLE, all dwait/iwait high, ram enables low.
